// File: rtl/light_mode_controller.sv
// light_mode_controller: manual/automatic light FSM with presence-driven auto-shutdown.
// Outputs are registered and follow the state on the same edge as the transition.
module light_mode_controller #(
    parameter int AUTO_SHUTDOWN_T = 30000,
    parameter int WARN_T          = 3000
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic infrared,
    output logic led,
    output logic auto_mode,
    output logic warn
);
    typedef enum logic [1:0] {MANUAL_OFF, MANUAL_ON, AUTO_OFF, AUTO_ON} state_t;
    localparam logic [15:0] LAST    = 16'(AUTO_SHUTDOWN_T - 1);
    localparam logic [15:0] WARN_AT = 16'(AUTO_SHUTDOWN_T - WARN_T);
    localparam logic        WARN_EN = WARN_T != 0;
    state_t      state, state_n;
    logic [15:0] timer, timer_n;
    logic        warn_n;
    always_comb begin
        state_n = state;
        timer_n = '0;
        case (state)
            MANUAL_OFF: state_n = a ? AUTO_OFF : b ? MANUAL_ON : MANUAL_OFF;
            MANUAL_ON:  state_n = a ? AUTO_OFF : b ? MANUAL_OFF : MANUAL_ON;
            AUTO_OFF:   state_n = a ? MANUAL_OFF : infrared ? AUTO_ON : AUTO_OFF;
            AUTO_ON: begin
                // idle count only advances on absence; reaching LAST ends the session
                state_n = a ? MANUAL_OFF : (!infrared && timer == LAST) ? AUTO_OFF : AUTO_ON;
                timer_n = (a || infrared || timer == LAST) ? 16'd0 : timer + 16'd1;
            end
            default:    state_n = MANUAL_OFF;
        endcase
        warn_n = WARN_EN && state_n == AUTO_ON && !infrared && timer_n >= WARN_AT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MANUAL_OFF;
            timer     <= '0;
            led       <= 1'b0;
            auto_mode <= 1'b0;
            warn      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            led       <= state_n == MANUAL_ON || state_n == AUTO_ON;
            auto_mode <= state_n == AUTO_OFF || state_n == AUTO_ON;
            warn      <= warn_n;
        end
    end
endmodule

// File: tb/tb_light_mode_controller.sv
// tb_light_mode_controller: directed vectors with a queued scoreboard checked by a monitor.
module tb_light_mode_controller;
    logic clk = 0, rst = 1, a = 0, b = 0, infrared = 0;
    logic led, auto_mode, warn;
    int checks = 0, errors = 0;
    logic [2:0] exp_q[$];

    light_mode_controller #(.AUTO_SHUTDOWN_T(10), .WARN_T(3)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .infrared(infrared),
        .led(led), .auto_mode(auto_mode), .warn(warn)
    );

    always #5 clk = ~clk;

    task automatic step(input logic sa, sb, si, el, ea, ew);
        @(negedge clk);
        a = sa; b = sb; infrared = si;
        exp_q.push_back({el, ea, ew});
    endtask

    task automatic check_now(input string name, input logic [2:0] want);
        checks++;
        if ({led, auto_mode, warn} !== want) begin
            errors++;
            $display("FAIL %s led/auto/warn got %b want %b", name, {led, auto_mode, warn}, want);
        end
    endtask

    initial begin : monitor
        int n = 0;
        logic [2:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({led, auto_mode, warn} !== want) begin
                    errors++;
                    $display("FAIL vec%0d led/auto/warn got %b want %b at %0t", n, {led, auto_mode, warn}, want, $time);
                end
                n++;
            end
        end
    end

    initial begin
        #12;
        check_now("reset", 3'b000);
        @(negedge clk);
        rst = 0;
        // manual toggle
        step(0, 1, 0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // auto session with full shutdown countdown
        step(1, 0, 0, 0, 1, 0);
        repeat (4) step(0, 0, 1, 1, 1, 0);
        for (int i = 1; i <= 10; i++) step(0, 0, 0, i < 10, 1, i >= 7 && i < 10);
        step(0, 0, 0, 0, 1, 0);
        // presence pulse restarts the count
        step(0, 0, 1, 1, 1, 0);
        for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, 1, i >= 7);
        step(0, 0, 1, 1, 1, 0);
        for (int i = 1; i <= 10; i++) step(0, 0, 0, i < 10, 1, i >= 7 && i < 10);
        // b ignored in AUTO_OFF and AUTO_ON
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 1, 0);
        for (int i = 1; i <= 10; i++) step(0, i == 3, 0, i < 10, 1, i >= 7 && i < 10);
        // async reset mid-session at timer=6
        step(0, 0, 1, 1, 1, 0);
        for (int i = 1; i <= 6; i++) step(0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #3 rst = 1;
        #1 check_now("async_rst", 3'b000);
        @(negedge clk);
        check_now("rst_held", 3'b000);
        rst = 0;
        repeat (3) step(0, 0, 1, 0, 0, 0);
        // a beats b from MANUAL_ON
        step(0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // held a acts once per cycle; a beats infrared in AUTO_ON
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/light_mode_controller.md
LIGHT_MODE_CONTROLLER -- requirements
Module: light_mode_controller

Interface
REQ-001 Parameter AUTO_SHUTDOWN_T, default 30000: consecutive infrared-low cycles in AUTO_ON before the light turns off; legal range 1..65535.
REQ-002 Parameter WARN_T, default 3000: cycles before shutdown during which warn is asserted; legal range 0..AUTO_SHUTDOWN_T.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a  input  1  mode-switch request, one-cycle pulse from the push-button decoder (long press).
REQ-006 b  input  1  light-toggle request, one-cycle pulse (short press).
REQ-007 infrared  input  1  presence sensor level, already synchronous to clk; 1 = presence.
REQ-008 led  output  1  light enable, registered.
REQ-009 auto_mode  output  1  1 = automatic mode active, registered.
REQ-010 warn  output  1  imminent auto-shutdown indicator, registered.

Function
REQ-011 The FSM SHALL have exactly four states: MANUAL_OFF, MANUAL_ON, AUTO_OFF, AUTO_ON.
REQ-012 A 16-bit idle timer SHALL count cycles in AUTO_ON with infrared=0.
REQ-013 MANUAL_OFF: a=1 -> AUTO_OFF; else b=1 -> MANUAL_ON; else stay.
REQ-014 MANUAL_ON: a=1 -> AUTO_OFF; else b=1 -> MANUAL_OFF; else stay.
REQ-015 AUTO_OFF: a=1 -> MANUAL_OFF; else infrared=1 -> AUTO_ON with timer=0; else stay; b ignored.
REQ-016 AUTO_ON: a=1 -> MANUAL_OFF with timer=0; else infrared=1 -> stay with timer=0; else (infrared=0) if timer==AUTO_SHUTDOWN_T-1 -> AUTO_OFF with timer=0, otherwise timer+1; b ignored.
REQ-017 Consequence: led SHALL fall on the edge that samples the AUTO_SHUTDOWN_T-th consecutive infrared=0 in AUTO_ON; any infrared=1 sample restarts the count.
REQ-018 The timer SHALL hold 0 in every state other than AUTO_ON and SHALL never wrap (bounded by REQ-016).
REQ-019 Priority on simultaneous inputs: a over b, and a over infrared; a pulse always switches mode regardless of other inputs.
REQ-020 a or b held high for N cycles SHALL act as N requests, one per cycle; no edge detection inside this block.
REQ-021 led SHALL be 1 in MANUAL_ON and AUTO_ON, 0 otherwise; it updates on the same edge as the state change (one-cycle latency from the sampled input).
REQ-022 auto_mode SHALL be 1 in AUTO_OFF and AUTO_ON, 0 otherwise, with the same timing as led.
REQ-023 warn SHALL be 1 only in AUTO_ON when next timer value >= AUTO_SHUTDOWN_T-WARN_T and infrared=0; it is 0 when WARN_T=0 and on the cycle the state leaves AUTO_ON.
REQ-024 Entering AUTO_OFF from manual mode SHALL turn led off even if it was on; infrared is evaluated starting the following cycle.

Reset
REQ-025 While rst=1 (asynchronously on assertion): state=MANUAL_OFF, timer=0, led=0, auto_mode=0, warn=0.
REQ-026 On rst deassertion, the first rising edge SHALL evaluate inputs normally from MANUAL_OFF; rst mid-AUTO_ON SHALL discard the timer count.

Verification (bench uses AUTO_SHUTDOWN_T=10, WARN_T=3)
REQ-027 Reset, then b pulse, wait 5 cycles, b pulse -> led 0->1 one edge after first b, 1->0 one edge after second b; auto_mode stays 0.
REQ-028 a pulse, infrared=1 for 4 cycles, then 0 -> auto_mode=1; led=1 one edge after infrared rises; led=0 exactly 10 edges after the first infrared=0 sample; warn=1 for the last 3 of those cycles only.
REQ-029 In AUTO_ON, infrared 0 for 8 cycles, 1 for 1 cycle, 0 again -> led stays 1 through the pulse and falls 10 edges after the restart; no shutdown at cycle 10 of the original count.
REQ-030 a and b asserted in the same cycle from MANUAL_ON -> AUTO_OFF, led=0, auto_mode=1; b has no effect.
REQ-031 rst asserted asynchronously mid-cycle in AUTO_ON with timer=6 -> led, auto_mode and warn fall immediately, before the next edge; after release, infrared=1 alone keeps led=0 (manual mode).
REQ-032 b pulses in AUTO_OFF and AUTO_ON -> no change to state, led or timer.
